// File: rtl/alorium_rand_fifo.sv
// rtl/alorium_rand_fifo.sv - LFSR byte prefetch FIFO with seed forwarding and flush
module alorium_rand_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_req,
    input  logic       seed_wr,
    input  logic [7:0] seed_in,
    input  logic [7:0] lfsr_data,
    output logic       lfsr_enable,
    output logic       lfsr_new_seed,
    output logic [7:0] lfsr_seed,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_empty,
    output logic       rd_full,
    output logic       underflow
);

    typedef enum logic [1:0] {RUN, SEED, SETTLE} state_t;

    state_t          state;
    logic            capt;
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];
    logic            seeding;
    logic            do_wr;
    logic            do_rd;
    logic [AW+1:0]   pending;

    assign seeding  = (state != RUN);
    assign rd_empty = (count == '0) || seeding;
    assign rd_full  = (count == (AW+1)'(DEPTH));
    assign do_wr    = capt && !seed_wr;
    assign do_rd    = rd_req && !seed_wr && !rd_empty;

    // Entries held plus bytes already requested from the LFSR; a same-cycle pop earns no credit.
    assign pending  = (AW+2)'(count) + (AW+2)'(capt) + (AW+2)'(lfsr_enable);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= lfsr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            capt          <= 1'b0;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            lfsr_enable   <= 1'b0;
            lfsr_new_seed <= 1'b0;
            lfsr_seed     <= 8'h00;
            rd_data       <= 8'h00;
            rd_valid      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            rd_valid      <= do_rd;
            lfsr_new_seed <= 1'b0;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end
            if (seed_wr) begin
                // Flush: the byte the LFSR is producing right now belongs to the old seed.
                state         <= SEED;
                capt          <= 1'b0;
                count         <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                lfsr_enable   <= 1'b0;
                lfsr_new_seed <= 1'b1;
                lfsr_seed     <= seed_in;
                underflow     <= 1'b0;
            end else begin
                capt        <= lfsr_enable;
                lfsr_enable <= !seeding && (pending < (AW+2)'(DEPTH));
                if (do_wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_rd) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({do_wr, do_rd})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (rd_req && rd_empty) begin
                    underflow <= 1'b1;
                end
                case (state)
                    SEED:    state <= SETTLE;
                    SETTLE:  state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alorium_rand_fifo.sv
// tb/tb_alorium_rand_fifo.sv - scoreboard bench for alorium_rand_fifo with an LFSR model
module tb_alorium_rand_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rd_req = 1'b0;
    logic       seed_wr = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] lfsr_data;
    logic       lfsr_enable;
    logic       lfsr_new_seed;
    logic [7:0] lfsr_seed;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic       rd_full;
    logic       underflow;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_pops = 0;
    int         seed_cnt = 0;
    logic       capt_m = 1'b0;
    logic       uf_m = 1'b0;
    logic [7:0] last_pop = 8'h00;
    logic [7:0] lfsr_q;
    logic [7:0] sb [$];

    alorium_rand_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_req        (rd_req),
        .seed_wr       (seed_wr),
        .seed_in       (seed_in),
        .lfsr_data     (lfsr_data),
        .lfsr_enable   (lfsr_enable),
        .lfsr_new_seed (lfsr_new_seed),
        .lfsr_seed     (lfsr_seed),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_empty      (rd_empty),
        .rd_full       (rd_full),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           lfsr_q <= 8'h01;
        else if (lfsr_new_seed) lfsr_q <= lfsr_seed;
        else if (lfsr_enable)   lfsr_q <= lfsr_step(lfsr_q);
    end
    assign lfsr_data = lfsr_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        capt_m   = 1'b0;
        uf_m     = 1'b0;
        seed_cnt = 0;
        last_pop = 8'h00;
    endtask

    // One clock: note inputs, advance the scoreboard across the edge, compare outputs.
    task automatic tick();
        logic       sw, rr, pe, pre_empty, exp_rd;
        logic [7:0] pd, si, exp_data;
        sw = seed_wr; rr = rd_req; pe = lfsr_enable; pd = lfsr_data; si = seed_in;
        pre_empty = (sb.size() == 0) || (seed_cnt != 0);
        exp_rd = 1'b0;
        exp_data = 8'h00;
        @(posedge clk);
        #1;
        if (sw) begin
            sb.delete();
            seed_cnt = 2;
            uf_m = 1'b0;
        end else begin
            if (seed_cnt != 0) seed_cnt--;
            if (rr && pre_empty) uf_m = 1'b1;
            if (rr && !pre_empty) begin
                exp_data = sb.pop_front();
                exp_rd = 1'b1;
            end
            if (capt_m) sb.push_back(pd);
        end
        capt_m = sw ? 1'b0 : pe;
        check("rd_valid", rd_valid, exp_rd);
        if (exp_rd) begin
            check("rd_data", rd_data, exp_data);
            last_pop = exp_data;
            n_pops++;
        end else begin
            check("rd_hold", rd_data, last_pop);
        end
        check("rd_empty", rd_empty, (sb.size() == 0) || (seed_cnt != 0));
        check("rd_full", rd_full, sb.size() == DEPTH);
        check("underflow", underflow, uf_m);
        check("new_seed", lfsr_new_seed, sw);
        if (sw) check("seed_val", lfsr_seed, si);
    endtask

    task automatic wait_full();
        for (int i = 0; i < 30 && sb.size() < DEPTH; i++) tick();
        check("fill_timeout", rd_full, 1'b1);
    endtask

    task automatic read_n(input int n, input logic no_seed, input logic [7:0] seed);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (no_seed) check("seed_leak", rd_data == seed, 1'b0);
        end
        rd_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic en_hist [1:10];
        logic em_hist [1:10];
        logic fu_hist [1:10];
        int   ones;
        int   p0;

        // Reset state
        #1;
        check("rst_enable", lfsr_enable, 1'b0);
        check("rst_new_seed", lfsr_new_seed, 1'b0);
        check("rst_seed", lfsr_seed, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_empty", rd_empty, 1'b1);
        check("rst_full", rd_full, 1'b0);
        check("rst_underflow", underflow, 1'b0);

        // T1: fill from reset release
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            en_hist[i] = lfsr_enable;
            em_hist[i] = rd_empty;
            fu_hist[i] = rd_full;
        end
        ones = 0;
        for (int i = 1; i <= 10; i++) ones += int'(en_hist[i]);
        check("t1_en_count", ones, 8);
        check("t1_en_first", en_hist[1], 1'b1);
        check("t1_en_last", en_hist[8], 1'b1);
        check("t1_en_off", en_hist[9], 1'b0);
        check("t1_empty_c1", em_hist[2], 1'b1);
        check("t1_empty_c2", em_hist[3], 1'b0);
        check("t1_full_c8", fu_hist[9], 1'b0);
        check("t1_full_c9", fu_hist[10], 1'b1);

        // T2: seed while full
        seed_wr = 1'b1;
        seed_in = 8'hAA;
        tick();
        seed_wr = 1'b0;
        check("t2_new_seed", lfsr_new_seed, 1'b1);
        check("t2_seed", lfsr_seed, 8'hAA);
        check("t2_empty0", rd_empty, 1'b1);
        check("t2_en0", lfsr_enable, 1'b0);
        tick();
        check("t2_empty1", rd_empty, 1'b1);
        check("t2_en1", lfsr_enable, 1'b0);
        tick();
        check("t2_empty2", rd_empty, 1'b1);
        wait_full();
        read_n(8, 1'b1, 8'hAA);

        // T3: back-to-back reads across pointer wraps
        wait_full();
        p0 = n_pops;
        read_n(40, 1'b0, 8'h00);
        check("t3_valid_count", n_pops - p0, 40);

        // T4: read while empty after a seed
        seed_wr = 1'b1;
        seed_in = 8'h3C;
        tick();
        seed_wr = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t4_no_valid", rd_valid, 1'b0);
        check("t4_underflow", underflow, 1'b1);
        seed_wr = 1'b1;
        tick();
        seed_wr = 1'b0;
        check("t4_uf_clear", underflow, 1'b0);

        // T5: seed colliding with a capture and a read
        for (int i = 0; i < 12 && !capt_m; i++) tick();
        check("t5_capt_found", capt_m, 1'b1);
        seed_wr = 1'b1;
        rd_req = 1'b1;
        seed_in = 8'h5C;
        tick();
        seed_wr = 1'b0;
        rd_req = 1'b0;
        check("t5_no_valid", rd_valid, 1'b0);
        check("t5_empty", rd_empty, 1'b1);
        check("t5_not_full", rd_full, 1'b0);
        for (int i = 0; i < 12 && sb.size() == 0; i++) tick();
        read_n(1, 1'b1, 8'h5C);
        check("t5_first", rd_data, lfsr_step(8'h5C));

        // T6: short asynchronous reset mid-fill
        for (int i = 0; i < 12 && sb.size() < 3; i++) tick();
        check("t6_midfill", lfsr_enable, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_enable", lfsr_enable, 1'b0);
        check("t6_empty", rd_empty, 1'b1);
        check("t6_full", rd_full, 1'b0);
        check("t6_valid", rd_valid, 1'b0);
        #2;
        reset_n = 1'b1;
        model_reset();
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ones += int'(lfsr_enable);
        end
        check("t6_en_count", ones, 8);
        wait_full();
        read_n(8, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
